// File: rtl/simple_rx_pkg.sv
// simple_rx_pkg
// Shared definitions for the simple_rx_stats receive/checker block:
// FSM state encoding, statistics register indices, header field offsets
// and the latency saturation value.
package simple_rx_pkg;

  typedef enum logic {
    HEAD = 1'b0,
    BODY = 1'b1
  } rx_state_t;

  localparam logic [3:0] REG_PKT_CNT  = 4'd0;
  localparam logic [3:0] REG_BYTE_CNT = 4'd1;
  localparam logic [3:0] REG_LAT_MIN  = 4'd2;
  localparam logic [3:0] REG_LAT_MAX  = 4'd3;
  localparam logic [3:0] REG_LAT_SUM  = 4'd4;
  localparam logic [3:0] REG_SEQ_ERR  = 4'd5;
  localparam logic [3:0] REG_LAST_SEQ = 4'd6;
  localparam logic [3:0] REG_STATUS   = 4'd7;

  localparam int TS_LSB  = 0;
  localparam int SEQ_LSB = 64;
  localparam int SEQ_W   = 32;
  localparam int LAT_W   = 32;

  localparam logic [LAT_W-1:0] LAT_SAT = 32'hFFFF_FFFF;

endpackage

// File: rtl/simple_rx_popcount.sv
// simple_rx_popcount
// Combinational population count of a byte-strobe vector.
// Ports:
//   strb  in   STRB_W  byte qualifiers
//   cnt   out  CNT_W   number of set bits (6 bits for a 32-bit strobe)
module simple_rx_popcount #(
  parameter int STRB_W = 32,
  parameter int CNT_W  = $clog2(STRB_W + 1)
) (
  input  logic [STRB_W-1:0] strb,
  output logic [CNT_W-1:0]  cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < STRB_W; i++) begin
      cnt = cnt + CNT_W'(strb[i]);
    end
  end

endmodule

// File: rtl/simple_rx_stats.sv
// simple_rx_stats
// AXI-Stream receive/checker for the simple_tx traffic generator. Extracts
// the TX timestamp and sequence number from each header beat, computes
// one-way latency against stamp_counter and keeps packet, byte, latency and
// (optionally) sequence-error statistics behind a 1-cycle read port.
//
// Optional feature: define SIMPLE_RX_SEQ_CHECK_EN to build sequence checking
// (registers 5 and 6); otherwise those registers read 0.
//
// Ports:
//   S_AXIS_ACLK     in   clock
//   S_AXIS_ARESET   in   synchronous active-high reset
//   S_AXIS_TDATA    in   stream data; [63:0] timestamp, [95:64] sequence
//   S_AXIS_TSTRB    in   byte qualifiers, popcount added to byte_cnt
//   S_AXIS_TUSER    in   ignored
//   S_AXIS_TVALID   in   beat valid
//   S_AXIS_TREADY   out  beat accept (1 from first cycle after reset)
//   S_AXIS_TLAST    in   last beat of packet
//   stamp_counter   in   free-running global time
//   ext_rst_count   in   clears statistics (not FSM state)
//   rd_addr         in   statistics register index
//   rd_data         out  registered read data
module simple_rx_stats
  import simple_rx_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int TIMESTAMP_WIDTH      = 64,
  parameter int C_STAT_WIDTH         = 32
) (
  input  logic                              S_AXIS_ACLK,
  input  logic                              S_AXIS_ARESET,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    S_AXIS_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
  input  logic                              S_AXIS_TVALID,
  output logic                              S_AXIS_TREADY,
  input  logic                              S_AXIS_TLAST,
  input  logic [TIMESTAMP_WIDTH-1:0]        stamp_counter,
  input  logic                              ext_rst_count,
  input  logic [3:0]                        rd_addr,
  output logic [31:0]                       rd_data
);

  localparam int STRB_W = C_S_AXIS_DATA_WIDTH / 8;
  localparam int CNT_W  = $clog2(STRB_W + 1);

  // Latency beyond the 32-bit range (including a timestamp from the
  // "future", which wraps to a huge difference) pins to LAT_SAT.
  function automatic logic [LAT_W-1:0] sat_lat(input logic [TIMESTAMP_WIDTH-1:0] diff);
    if (|diff[TIMESTAMP_WIDTH-1:LAT_W]) return LAT_SAT;
    return diff[LAT_W-1:0];
  endfunction

  function automatic logic [C_STAT_WIDTH-1:0] sat_add(input logic [C_STAT_WIDTH-1:0] a,
                                                      input logic [LAT_W-1:0]        b);
    logic [C_STAT_WIDTH:0] s;
    s = {1'b0, a} + (C_STAT_WIDTH+1)'(b);
    if (s[C_STAT_WIDTH]) return '1;
    return s[C_STAT_WIDTH-1:0];
  endfunction

  rx_state_t state_p0, state_nxt;
  logic      tready_p0;
  logic      accept, hdr_acc, eop;

  logic [TIMESTAMP_WIDTH-1:0] ts, diff;
  logic [LAT_W-1:0]           lat_now, lat_p1, lat_cur;
  logic [CNT_W-1:0]           strb_cnt;

  logic [C_STAT_WIDTH-1:0] pkt_cnt, byte_cnt, lat_sum, seq_err_cnt;
  logic [LAT_W-1:0]        lat_min, lat_max;
  logic [SEQ_W-1:0]        last_seq;
  logic [31:0]             rd_mux;

  logic unused_bits;
  assign unused_bits = ^{S_AXIS_TUSER, S_AXIS_TDATA};

  assign S_AXIS_TREADY = tready_p0;
  assign accept        = S_AXIS_TVALID & tready_p0;
  assign hdr_acc       = accept & (state_p0 == HEAD);
  assign eop           = accept & S_AXIS_TLAST;

  assign ts      = S_AXIS_TDATA[TS_LSB +: TIMESTAMP_WIDTH];
  assign diff    = stamp_counter - ts;
  assign lat_now = sat_lat(diff);
  // A single-beat packet ends on its header, so use the live value there.
  assign lat_cur = (state_p0 == HEAD) ? lat_now : lat_p1;

  simple_rx_popcount #(
    .STRB_W (STRB_W),
    .CNT_W  (CNT_W)
  ) u_popcount (
    .strb (S_AXIS_TSTRB),
    .cnt  (strb_cnt)
  );

  // ---- stage p0: FSM and handshake ----
  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      state_p0  <= HEAD;
      tready_p0 <= 1'b0;
    end else begin
      state_p0  <= state_nxt;
      tready_p0 <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state_p0;
    if (accept) begin
      if (S_AXIS_TLAST) state_nxt = HEAD;
      else              state_nxt = BODY;
    end
  end

  // ---- stage p1: header latency held for the rest of the packet ----
  always_ff @(posedge S_AXIS_ACLK) begin
    if (hdr_acc) lat_p1 <= lat_now;
  end

  // Statistics; an ext_rst_count pulse beats a coincident TLAST.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET || ext_rst_count) begin
      pkt_cnt  <= '0;
      byte_cnt <= '0;
      lat_sum  <= '0;
      lat_min  <= LAT_SAT;
      lat_max  <= '0;
    end else begin
      if (accept) byte_cnt <= byte_cnt + C_STAT_WIDTH'(strb_cnt);
      if (eop) begin
        pkt_cnt <= pkt_cnt + 1'b1;
        lat_sum <= sat_add(lat_sum, lat_cur);
        if (lat_cur < lat_min) lat_min <= lat_cur;
        if (lat_cur > lat_max) lat_max <= lat_cur;
      end
    end
  end

`ifdef SIMPLE_RX_SEQ_CHECK_EN
  logic [SEQ_W-1:0] seq, expected_seq;
  assign seq = S_AXIS_TDATA[SEQ_LSB +: SEQ_W];

  // The first packet after reset/clear has no reference, so it never errors.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      seq_err_cnt  <= '0;
      expected_seq <= '0;
      last_seq     <= '0;
    end else if (ext_rst_count) begin
      seq_err_cnt  <= '0;
      expected_seq <= '0;
    end else if (hdr_acc) begin
      if ((seq != expected_seq) && (pkt_cnt != '0)) seq_err_cnt <= seq_err_cnt + 1'b1;
      expected_seq <= seq + 1'b1;
      last_seq     <= seq;
    end
  end
`else
  assign seq_err_cnt = '0;
  assign last_seq    = '0;
`endif

  // ---- stage p2: registered read port ----
  always_comb begin
    rd_mux = '0;
    case (rd_addr)
      REG_PKT_CNT:  rd_mux = 32'(pkt_cnt);
      REG_BYTE_CNT: rd_mux = 32'(byte_cnt);
      REG_LAT_MIN:  rd_mux = lat_min;
      REG_LAT_MAX:  rd_mux = lat_max;
      REG_LAT_SUM:  rd_mux = 32'(lat_sum);
      REG_SEQ_ERR:  rd_mux = 32'(seq_err_cnt);
      REG_LAST_SEQ: rd_mux = last_seq;
      REG_STATUS:   rd_mux = {30'b0, state_p0 == BODY, tready_p0};
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) rd_data <= '0;
    else               rd_data <= rd_mux;
  end

endmodule

// File: tb/tb_simple_rx_stats.sv
module tb_simple_rx_stats;

  localparam logic [31:0] E = 32'hFFFF_FFFF;

  logic         clk = 1'b0;
  logic         areset;
  logic [255:0] tdata;
  logic [31:0]  tstrb;
  logic [127:0] tuser;
  logic         tvalid, tready, tlast;
  logic [63:0]  stamp;
  logic         ext_rst;
  logic [3:0]   rd_addr;
  logic [31:0]  rd_data;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  simple_rx_stats dut (
    .S_AXIS_ACLK   (clk),
    .S_AXIS_ARESET (areset),
    .S_AXIS_TDATA  (tdata),
    .S_AXIS_TSTRB  (tstrb),
    .S_AXIS_TUSER  (tuser),
    .S_AXIS_TVALID (tvalid),
    .S_AXIS_TREADY (tready),
    .S_AXIS_TLAST  (tlast),
    .stamp_counter (stamp),
    .ext_rst_count (ext_rst),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data)
  );

  typedef struct {
    logic [63:0] ts;
    logic [31:0] seq;
    logic [63:0] stamp;
    logic [31:0] strb;
    logic        last;
    logic        clr;
    logic        chk;
    logic [31:0] e_pkt, e_byte, e_min, e_max, e_sum, e_status;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic beat(input logic [63:0] ts, input logic [31:0] seq, input logic [63:0] st,
                      input logic [31:0] strb, input logic last, input logic clr);
    tdata          = '0;
    tdata[255:96]  = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    tdata[63:0]    = ts;
    tdata[95:64]   = seq;
    tuser          = {$urandom(), $urandom(), $urandom(), $urandom()};
    stamp          = st;
    tstrb          = strb;
    tlast          = last;
    ext_rst        = clr;
    tvalid         = 1'b1;
    @(posedge clk); #1;
    tvalid  = 1'b0;
    tlast   = 1'b0;
    ext_rst = 1'b0;
  endtask

  task automatic pulse_clr();
    ext_rst = 1'b1;
    @(posedge clk); #1;
    ext_rst = 1'b0;
  endtask

  task automatic chk_reg(input string name, input logic [3:0] addr, input logic [31:0] exp);
    rd_addr = addr;
    @(posedge clk); #1;
    check(name, rd_data, exp);
  endtask

  task automatic chk_stats(input string tag, input logic [31:0] p, input logic [31:0] b,
                           input logic [31:0] mn, input logic [31:0] mx, input logic [31:0] s,
                           input logic [31:0] st);
    chk_reg({tag, ".pkt_cnt"},  4'd0, p);
    chk_reg({tag, ".byte_cnt"}, 4'd1, b);
    chk_reg({tag, ".lat_min"},  4'd2, mn);
    chk_reg({tag, ".lat_max"},  4'd3, mx);
    chk_reg({tag, ".lat_sum"},  4'd4, s);
    chk_reg({tag, ".status"},   4'd7, st);
  endtask

  initial begin
    areset  = 1'b1;
    tdata   = '0;
    tstrb   = '0;
    tuser   = '0;
    tvalid  = 1'b0;
    tlast   = 1'b0;
    stamp   = '0;
    ext_rst = 1'b0;
    rd_addr = 4'd0;

    // Table: ts, seq, stamp, strb, last, clr, chk, pkt, byte, min, max, sum, status
    vq.push_back('{64'd100, 0, 64'd130, E, 1, 0, 1, 1, 32, 30, 30, 30, 1});
    vq.push_back('{64'd0, 0, 64'd0, 0, 0, 1, 1, 0, 0, E, 0, 0, 1});
    vq.push_back('{64'd0, 0, 64'd5, E, 0, 0, 1, 0, 32, E, 0, 0, 3});
    vq.push_back('{64'd0, 0, 64'd0, E, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    vq.push_back('{64'd0, 0, 64'd0, 32'hF, 1, 0, 1, 1, 68, 5, 5, 5, 1});
    vq.push_back('{64'd0, 0, 64'd0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0});
    vq.push_back('{64'd1000, 0, 64'd1010, E, 1, 0, 0, 0, 0, 0, 0, 0, 0});
    vq.push_back('{64'd2000, 0, 64'd2004, E, 1, 0, 1, 2, 64, 4, 10, 14, 1});
    vq.push_back('{64'd0, 0, 64'd0, 0, 0, 1, 1, 0, 0, E, 0, 0, 1});
    vq.push_back('{64'd0, 0, 64'h2_0000_0000, E, 1, 0, 1, 1, 32, E, E, E, 1});
    vq.push_back('{64'd501, 0, 64'd500, E, 1, 0, 1, 2, 64, E, E, E, 1});
    vq.push_back('{64'd0, 0, 64'd0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0});
    vq.push_back('{64'd10, 0, 64'd10, E, 1, 0, 1, 1, 32, 0, 0, 0, 1});
    vq.push_back('{64'd0, 0, 64'hFFFF_FFF0, E, 1, 0, 1, 2, 64, 0, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 1});
    vq.push_back('{64'd100, 0, 64'h120, 32'hFF, 1, 0, 1, 3, 72, 0, 32'hFFFF_FFF0, E, 1});
    vq.push_back('{64'd0, 0, 64'h1_0000_0000, 32'h1, 1, 0, 1, 4, 73, 0, E, E, 1});

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset.tready", {31'b0, tready}, 32'd0);
    check("reset.rd_data", rd_data, 32'd0);
    areset = 1'b0;
    @(posedge clk); #1;
    check("release.tready", {31'b0, tready}, 32'd1);
    chk_stats("reset", 0, 0, E, 0, 0, 1);

    // Table-driven packets
    foreach (vq[i]) begin
      if (vq[i].clr) pulse_clr();
      else beat(vq[i].ts, vq[i].seq, vq[i].stamp, vq[i].strb, vq[i].last, 1'b0);
      if (vq[i].chk)
        chk_stats($sformatf("vec%0d", i), vq[i].e_pkt, vq[i].e_byte, vq[i].e_min,
                  vq[i].e_max, vq[i].e_sum, vq[i].e_status);
    end

    // Clear while a packet is in flight: the packet still counts at TLAST,
    // with only the tail bytes and the header's latency.
    pulse_clr();
    beat(64'd0, 0, 64'd7, E, 1'b0, 1'b0);
    pulse_clr();
    beat(64'd0, 0, 64'd999, 32'hF, 1'b1, 1'b0);
    chk_stats("inflight", 1, 4, 7, 7, 7, 1);

    // Clear coinciding with a TLAST beat wins
    beat(64'd0, 0, 64'd9, E, 1'b1, 1'b1);
    chk_stats("clr_tlast", 0, 0, E, 0, 0, 1);

    // Sequence checking: 0,1,3,4 -> one error
    pulse_clr();
    beat(64'd0, 32'd0, 64'd1, E, 1'b1, 1'b0);
    beat(64'd0, 32'd1, 64'd1, E, 1'b1, 1'b0);
    beat(64'd0, 32'd3, 64'd1, E, 1'b1, 1'b0);
    beat(64'd0, 32'd4, 64'd1, E, 1'b1, 1'b0);
    chk_reg("seq.pkt_cnt", 4'd0, 32'd4);
`ifdef SIMPLE_RX_SEQ_CHECK_EN
    chk_reg("seq.seq_err_cnt", 4'd5, 32'd1);
    chk_reg("seq.last_seq", 4'd6, 32'd4);
`else
    chk_reg("seq.seq_err_cnt", 4'd5, 32'd0);
    chk_reg("seq.last_seq", 4'd6, 32'd0);
`endif
    chk_reg("unmapped.reg8", 4'd8, 32'd0);
    chk_reg("unmapped.reg15", 4'd15, 32'd0);

    // Reset in the middle of a 4-beat packet
    beat(64'd0, 0, 64'd50, E, 1'b0, 1'b0);
    beat(64'd0, 0, 64'd50, E, 1'b0, 1'b0);
    areset = 1'b1;
    @(posedge clk); #1;
    check("midreset.tready", {31'b0, tready}, 32'd0);
    @(posedge clk); #1;
    check("midreset.tready2", {31'b0, tready}, 32'd0);
    areset = 1'b0;
    @(posedge clk); #1;
    check("midreset.release_tready", {31'b0, tready}, 32'd1);
    beat(64'd0, 0, 64'd3, E, 1'b1, 1'b0);
    chk_stats("midreset", 1, 32, 3, 3, 3, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/simple_rx_stats.md
Name: simple_rx_stats

Overview:
AXI-Stream receive/checker end for the simple_tx traffic generator. It consumes packets on the loopback S_AXIS path and extracts the 64-bit TX timestamp and sequence number from each header beat. It computes one-way latency against the global stamp_counter and keeps packet, byte, latency and sequence-error statistics. Statistics are readable through a 1-cycle-latency register read port that an AXI-lite wrapper maps.

Parameters:
C_S_AXIS_DATA_WIDTH, 256, stream data width (bits); must be at least 96.
C_S_AXIS_TUSER_WIDTH, 128, tuser width; accepted and ignored.
TIMESTAMP_WIDTH, 64, width of stamp_counter and of the embedded timestamp.
C_STAT_WIDTH, 32, width of every statistics counter.

Ports:
S_AXIS_ACLK  in  1  clock; all logic sampled on the rising edge.
S_AXIS_ARESET  in  1  synchronous, active-high reset.
S_AXIS_TDATA  in  C_S_AXIS_DATA_WIDTH  stream data.
S_AXIS_TSTRB  in  C_S_AXIS_DATA_WIDTH/8  byte qualifiers.
S_AXIS_TUSER  in  C_S_AXIS_TUSER_WIDTH  unused.
S_AXIS_TVALID  in  1  beat valid.
S_AXIS_TREADY  out  1  beat accept.
S_AXIS_TLAST  in  1  last beat of packet.
stamp_counter  in  TIMESTAMP_WIDTH  free-running global time.
ext_rst_count  in  1  1-cycle pulse; clears all statistics.
rd_addr  in  4  statistics register index.
rd_data  out  32  registered read data.

Behaviour:
- Reset: S_AXIS_TREADY=0, rd_data=0, all counters=0, lat_min=all-ones, FSM=HEAD, expected_seq=0. TREADY goes to 1 on the first cycle after reset deasserts and stays 1; there is no backpressure.
- A beat is accepted when TVALID&TREADY.
- FSM HEAD, on an accepted beat:
  - Capture ts=TDATA[63:0] and seq=TDATA[95:64].
  - Compute lat=stamp_counter-ts modulo 2^64. If lat exceeds 2^32-1, saturate to 32'hFFFF_FFFF.
  - Transition: TLAST=1 -> stay HEAD; otherwise -> BODY.
- FSM BODY: accepted beat with TLAST=1 -> HEAD.
- Byte accounting: on every accepted beat, byte_cnt += popcount(TSTRB).
- End of packet (accepted TLAST beat, including a single-beat packet):
  - pkt_cnt+1.
  - lat_sum += lat, saturating at all-ones.
  - lat_min=min(lat_min,lat); lat_max=max(lat_max,lat).
- Counter width rules: pkt_cnt and byte_cnt wrap at 2^C_STAT_WIDTH. lat_sum saturates.
- ext_rst_count: clears counters and min/max on the next edge. It does not touch FSM state; a packet in flight is still counted at its TLAST. If the pulse coincides with a TLAST beat, the clear wins and that packet is not counted.
- Reset mid-packet: FSM returns to HEAD. The partial packet is discarded and the next accepted beat is treated as a header.
- Read port, rd_data registered one cycle after rd_addr:
  - 0 pkt_cnt, 1 byte_cnt, 2 lat_min, 3 lat_max, 4 lat_sum, 5 seq_err_cnt.
  - 6 last_seq, 7 {30'b0, state==BODY, TREADY}.
  - Any other address returns 0.
- Latency: statistics are visible at rd_data 2 cycles after the TLAST beat is accepted.

Optional Feature:
Macro SIMPLE_RX_SEQ_CHECK_EN.
- Defined, on each header:
  - If seq != expected_seq: seq_err_cnt+1, but only when pkt_cnt != 0 (so the first packet never errors).
  - expected_seq=seq+1, wrapping modulo 2^32.
  - last_seq=seq.
  - ext_rst_count clears seq_err_cnt and resets expected_seq to 0.
- Undefined: no sequence logic is built; register 5 reads 0; register 6 reads 0.

Decomposition:
- Package simple_rx_pkg:
  - FSM state encoding HEAD=1'b0, BODY=1'b1.
  - Register index constants REG_PKT_CNT..REG_STATUS.
  - Header field offsets TS_LSB=0, SEQ_LSB=64.
  - LAT_SAT=32'hFFFF_FFFF.
- One sub-module simple_rx_popcount: parameterised combinational byte-strobe popcount of width C_S_AXIS_DATA_WIDTH/8, producing a 6-bit result for a 32-bit strobe.

Test Plan:
- Single-beat packet: TDATA[63:0]=100 with stamp_counter=130, TSTRB=all-ones, TLAST=1 -> pkt_cnt=1, byte_cnt=32, lat_min=lat_max=lat_sum=30.
- 3-beat packet: headers lat=5, TSTRB 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_000F -> pkt_cnt=1, byte_cnt=68, FSM back to HEAD, register 7 reads 1.
- Two packets with lat 10 then 4 -> lat_min=4, lat_max=10, lat_sum=14. Then pulse ext_rst_count -> all counters 0, lat_min=32'hFFFF_FFFF.
- Timestamp older than stamp_counter by 2^33 -> lat_max=32'hFFFF_FFFF. Timestamp ahead by 1 (wrap) -> lat saturates to 32'hFFFF_FFFF.
- With SIMPLE_RX_SEQ_CHECK_EN, send seq 0,1,3,4 -> seq_err_cnt=1, last_seq=4. Without the macro, registers 5 and 6 read 0.
- Assert S_AXIS_ARESET after the 2nd beat of a 4-beat packet, then send a 1-beat packet -> pkt_cnt=1, byte_cnt=32, TREADY=0 during reset and 1 one cycle after release.
